// File: rtl/denise_clx_ctrl_pkg.sv
// Shared Denise collision-control definitions: register address, FIFO sizing,
// event word layout and the clxdat read-FSM state type.
package denise_clx_ctrl_pkg;

    localparam logic [8:1] CLXDAT_ADDR    = 8'h07;  // byte address 0x00E, word-addressed
    localparam int         CLX_FIFO_DEPTH = 4;

    localparam int HITS_W      = 15;
    localparam int VPOS_W      = 9;
    localparam int EV_W        = VPOS_W + HITS_W;
    localparam int EV_HITS_LSB = 0;
    localparam int EV_VPOS_LSB = HITS_W;

    typedef enum logic [1:0] {
        CLX_IDLE  = 2'd0,
        CLX_READ  = 2'd1,
        CLX_CLEAR = 2'd2
    } clx_state_e;

    function automatic logic [EV_W-1:0] pack_event(input logic [VPOS_W-1:0] vp,
                                                   input logic [HITS_W-1:0] hits);
        logic [EV_W-1:0] ev;
        ev = '0;
        ev[EV_VPOS_LSB +: VPOS_W] = vp;
        ev[EV_HITS_LSB +: HITS_W] = hits;
        return ev;
    endfunction

endpackage

// File: rtl/denise_clx_ctrl_if.sv
// Host-side collision event stream: valid/ready handshake plus overflow/clear.
interface denise_clx_ctrl_if;
    import denise_clx_ctrl_pkg::*;

    logic            ev_valid;
    logic            ev_ready;
    logic [EV_W-1:0] ev_data;
    logic            ev_overflow;
    logic            ev_clr;

    modport master (
        output ev_valid,
        output ev_data,
        output ev_overflow,
        input  ev_ready,
        input  ev_clr
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        input  ev_overflow,
        output ev_ready,
        output ev_clr
    );

endinterface

// File: rtl/denise_clx_ctrl_fifo.sv
// Collision event FIFO with extra-MSB pointers; flush overrides push and pop.
module clx_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         wr_en;
    logic         rd_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/denise_clx_ctrl.sv
// Denise collision control: CLXDAT read-to-clear register and per-line
// collision event capture into a host-readable FIFO.
module denise_clx_ctrl
    import denise_clx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = CLX_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk7_en,
    input  logic [8:1]          reg_address_in,
    output logic [15:0]         data_out,
    input  logic [HITS_W-1:0]   cl_in,
    input  logic                window,
    input  logic                eol,
    input  logic [VPOS_W-1:0]   vpos,
    denise_clx_ctrl_if.master   ev
);

    clx_state_e        state_q, state_d;
    logic [HITS_W-1:0] clxdat_q, clxdat_d;
    logic [HITS_W-1:0] linecl_q, linecl_d;
    logic              ovf_q, ovf_d;

    logic [HITS_W-1:0] g;
    logic [HITS_W-1:0] line_hits;
    logic              addr_hit;
    logic              push_req;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;

    assign g         = cl_in & {HITS_W{window}};
    assign addr_hit  = (reg_address_in == CLXDAT_ADDR);
    assign line_hits = linecl_q | g;

    assign data_out = addr_hit ? {1'b1, clxdat_q} : 16'h0000;

    // Read-to-clear: the cycle after a read ends reloads clxdat with the live hits.
    always_comb begin
        state_d  = state_q;
        clxdat_d = clxdat_q;
        if (clk7_en) begin
            unique case (state_q)
                CLX_IDLE: begin
                    clxdat_d = clxdat_q | g;
                    if (addr_hit) state_d = CLX_READ;
                end
                CLX_READ: begin
                    clxdat_d = clxdat_q | g;
                    if (!addr_hit) state_d = CLX_CLEAR;
                end
                CLX_CLEAR: begin
                    clxdat_d = g;
                    state_d  = addr_hit ? CLX_READ : CLX_IDLE;
                end
                default: begin
                    clxdat_d = '0;
                    state_d  = CLX_IDLE;
                end
            endcase
        end
    end

    assign push_req = clk7_en && eol && (line_hits != '0);
    assign pop      = ev.ev_valid && ev.ev_ready;
    assign accept   = !fifo_full || pop;

    always_comb begin
        linecl_d = linecl_q;
        if (clk7_en) linecl_d = eol ? '0 : line_hits;
        ovf_d = ovf_q;
        if (ev.ev_clr)                  ovf_d = 1'b0;
        else if (push_req && !accept)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CLX_IDLE;
            clxdat_q <= '0;
            linecl_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clxdat_q <= clxdat_d;
            linecl_q <= linecl_d;
            ovf_q    <= ovf_d;
        end
    end

    clx_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_req),
        .pop_i   (pop),
        .flush_i (ev.ev_clr),
        .din_i   (pack_event(vpos, line_hits)),
        .dout_o  (ev.ev_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ev.ev_valid    = !fifo_empty;
    assign ev.ev_overflow = ovf_q;

endmodule

// File: tb/tb_denise_clx_ctrl.sv
// Bench for denise_clx_ctrl: directed scenarios then randomized traffic, all
// checked against a behavioural model of the collision register and event queue.
module tb_denise_clx_ctrl;

    localparam logic [7:0] CLX   = 8'h07;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [15:0] data_out;
    logic [14:0] cl_in;
    logic        window;
    logic        eol;
    logic [8:0]  vpos;

    denise_clx_ctrl_if evif ();

    denise_clx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_out       (data_out),
        .cl_in          (cl_in),
        .window         (window),
        .eol            (eol),
        .vpos           (vpos),
        .ev             (evif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [14:0] m_clx;
    logic [14:0] m_line;
    bit          m_ovf;
    bit          a1, a2;      // address-match on the last two enabled cycles
    logic [23:0] mq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_clx  = '0;
        m_line = '0;
        m_ovf  = 1'b0;
        a1     = 1'b0;
        a2     = 1'b0;
        mq.delete();
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic tick();
        logic [14:0] g;
        logic [15:0] exp_dout;
        bit          pop, was_full;
        #1;
        exp_dout = (reg_address_in == CLX) ? {1'b1, m_clx} : 16'h0000;
        chk("data_out", 32'(data_out), 32'(exp_dout));
        chk("ev_valid", 32'(evif.ev_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("ev_data", 32'(evif.ev_data), 32'(mq[0]));
        chk("ev_overflow", 32'(evif.ev_overflow), 32'(m_ovf));

        g        = cl_in & {15{window}};
        pop      = (mq.size() != 0) && evif.ev_ready;
        was_full = (mq.size() == DEPTH);
        if (evif.ev_clr) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (clk7_en && eol && ((m_line | g) != '0)) begin
                if (!was_full || pop) mq.push_back({vpos, m_line | g});
                else                  m_ovf = 1'b1;
            end
        end
        if (clk7_en) begin
            m_line = eol ? 15'h0 : (m_line | g);
            m_clx  = (a2 && !a1) ? g : (m_clx | g);
            a2     = a1;
            a1     = (reg_address_in == CLX);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input bit en, input logic [7:0] addr, input logic [14:0] cl,
                       input bit win, input bit e, input logic [8:0] vp,
                       input bit rdy, input bit clr);
        clk7_en        = en;
        reg_address_in = addr;
        cl_in          = cl;
        window         = win;
        eol            = e;
        vpos           = vp;
        evif.ev_ready  = rdy;
        evif.ev_clr    = clr;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_ev_valid", 32'(evif.ev_valid), 32'h0);
        chk("rst_ev_overflow", 32'(evif.ev_overflow), 32'h0);
        chk("rst_ev_data", 32'(evif.ev_data), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra;
        logic [8:0]  rv;
        logic [14:0] rcl;
        bit          ren, rwin, reol, rrdy, rclr;

        reset_n        = 1'b0;
        clk7_en        = 1'b0;
        reg_address_in = 8'h00;
        cl_in          = 15'h0;
        window         = 1'b0;
        eol            = 1'b0;
        vpos           = 9'd0;
        evif.ev_ready  = 1'b0;
        evif.ev_clr    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(evif.ev_valid), 32'h0);
        chk("rst_ovf", 32'(evif.ev_overflow), 32'h0);
        chk("rst_evdata", 32'(evif.ev_data), 32'h0);
        reset_n = 1'b1;

        // Hits accumulate, then a two-cycle read and the clearing cycle
        repeat (3) cyc(1'b1, 8'h00, 15'h0003, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, CLX,   15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        chk("clx_read_8003", 32'(data_out), 32'h8003);
        repeat (2) cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        cyc(1'b1, CLX, 15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        chk("clx_cleared_8000", 32'(data_out), 32'h8000);

        // Hit landing exactly in the clear cycle survives
        cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 15'h0100, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        cyc(1'b1, CLX,   15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        chk("clx_clear_hit_8100", 32'(data_out), 32'h8100);
        repeat (2) cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0);

        // End of line pushes the accumulated hits of the line
        cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b1, 9'd1, 1'b0, 1'b0);
        chk("line1_valid", 32'(evif.ev_valid), 32'h1);
        chk("line1_data", 32'(evif.ev_data), 32'({9'd1, 15'h0103}));
        cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd1, 1'b0, 1'b1);
        chk("clr_empty", 32'(evif.ev_valid), 32'h0);

        // Hits outside the window are ignored
        repeat (16) cyc(1'b1, 8'h00, 15'h7FFF, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 15'h7FFF, 1'b0, 1'b1, 9'd2, 1'b0, 1'b0);
        chk("nowin_no_push", 32'(evif.ev_valid), 32'h0);
        cyc(1'b1, CLX, 15'h0000, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0);
        chk("nowin_clx_8000", 32'(data_out), 32'h8000);
        repeat (2) cyc(1'b1, 8'h00, 15'h0000, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0);

        // Five hit lines into a four-entry FIFO with no consumer
        for (int v = 10; v <= 14; v++) begin
            cyc(1'b1, 8'h00, 15'h0001, 1'b1, 1'b0, 9'(v), 1'b0, 1'b0);
            cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b1, 9'(v), 1'b0, 1'b0);
        end
        chk("ovf_set", 32'(evif.ev_overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(evif.ev_data), 32'({9'(10 + i), 15'h0001}));
            cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd15, 1'b1, 1'b0);
        end
        chk("drained_empty", 32'(evif.ev_valid), 32'h0);
        chk("ovf_sticky", 32'(evif.ev_overflow), 32'h1);
        cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd15, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(evif.ev_overflow), 32'h0);

        // Full FIFO with a simultaneous pop accepts the new line
        for (int v = 20; v <= 23; v++) begin
            cyc(1'b1, 8'h00, 15'h0001, 1'b1, 1'b0, 9'(v), 1'b0, 1'b0);
            cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b1, 9'(v), 1'b0, 1'b0);
        end
        cyc(1'b1, 8'h00, 15'h0004, 1'b1, 1'b0, 9'd24, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b1, 9'd24, 1'b1, 1'b0);
        chk("full_pop_no_ovf", 32'(evif.ev_overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("full_pop_order", 32'(evif.ev_data[23:15]), 32'(21 + i));
            cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd25, 1'b1, 1'b0);
        end
        chk("full_pop_count", 32'(evif.ev_valid), 32'h0);

        // Reset in the middle of a read with two entries queued
        for (int v = 30; v <= 31; v++) begin
            cyc(1'b1, 8'h00, 15'h0010, 1'b1, 1'b0, 9'(v), 1'b0, 1'b0);
            cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b1, 9'(v), 1'b0, 1'b0);
        end
        cyc(1'b1, CLX, 15'h0000, 1'b1, 1'b0, 9'd32, 1'b0, 1'b0);
        do_reset();
        reg_address_in = 8'h00;
        #1;
        chk("rst_mid_dout", 32'(data_out), 32'h0);
        chk("rst_mid_valid", 32'(evif.ev_valid), 32'h0);
        chk("rst_mid_ovf", 32'(evif.ev_overflow), 32'h0);
        repeat (3) cyc(1'b1, 8'h00, 15'h0000, 1'b1, 1'b0, 9'd33, 1'b0, 1'b0);
        chk("rst_no_phantom", 32'(evif.ev_valid), 32'h0);

        // Randomized traffic against the model
        ra = 8'h00;
        rv = 9'd40;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    ra = CLX;
                    2:       ra = 8'h00;
                    default: ra = 8'h12;
                endcase
            end
            ren  = ($urandom_range(0, 1) == 1);
            rcl  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'h0;
            rwin = ($urandom_range(0, 3) != 0);
            reol = ($urandom_range(0, 5) == 0);
            rrdy = ($urandom_range(0, 2) == 0);
            rclr = ($urandom_range(0, 80) == 0);
            cyc(ren, ra, rcl, rwin, reol, rv, rrdy, rclr);
            if (ren && reol) rv = rv + 9'd1;
            if (i == 400) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
